dummy_adc: RTL and testbench
============================

// Module: dummy_adc
// PURPOSE
//  Stand-in for a nonexistent ADC: the capture-side counterpart of the dummy DAC.
//  Samples the 6-bit slot data port at a fixed rate, frames each sample into a
//  4-byte message and writes it into the slot's FIFO through the byte write port.
//  Sits between the slot pins and the slot FIFO; occupancy comes from FIFO pointers.
// PARAMETERS
//  SAMPLE_DIV  256  clk cycles per sample tick (100 MHz / 256 = 390.6 kHz); must be >= 8
//  ADDR_W      11   FIFO pointer width; FIFO depth = 2**ADDR_W bytes
// PORTS
//  clk             in   1       system clock, all logic on rising edge
//  reset           in   1       asynchronous, active-low reset
//  slot_data       in   6       sample bits from converter slot
//  direction       in   1       1 = slot driving in (capture enabled), 0 = idle
//  channels        in   1       0 = mono, 1 = stereo
//  fifo_clk        out  1       message strobe: toggles once per completed message
//  fifo_data       out  8       byte to FIFO, valid while fifo_write = 1
//  fifo_write      out  1       write enable, one byte per cycle
//  fifo_addr_in    in   ADDR_W  FIFO write pointer
//  fifo_addr_out   in   ADDR_W  FIFO read pointer
//  overflow_count  out  8       dropped-message count, saturates at 255
// BEHAVIOUR
//  - Reset (reset = 0, async): fifo_clk=0, fifo_write=0, fifo_data=0, overflow_count=0,
//    seq=0, tick counter=0, state=IDLE. A partial message is abandoned, never resumed.
//  - Tick counter runs 0..SAMPLE_DIV-1 and wraps; tick = (counter == SAMPLE_DIV-1).
//  - used = (fifo_addr_in - fifo_addr_out) mod 2**ADDR_W; free = 2**ADDR_W - 1 - used.
//  - FSM states IDLE, CAP_R, WRITE; all outputs registered.
//  - IDLE, tick, direction=0: nothing happens, no overflow count.
//  - IDLE, tick, direction=1, free < 4: drop the message, overflow_count++ (saturating), seq unchanged.
//  - IDLE, tick, direction=1, free >= 4: L <= slot_data.
//      mono: R <= slot_data (same cycle), go to WRITE.
//      stereo: go to CAP_R.
//  - CAP_R: R <= slot_data (slot presents right channel one cycle after left), go to WRITE.
//  - WRITE: byte index 0..3, fifo_write=1 on 4 consecutive cycles. Bytes, in order:
//      b0 = {2'b10, seq[5:0]}
//      b1 = {2'b00, L}
//      b2 = {2'b00, R}
//      b3 = b0 ^ b1 ^ b2
//  - After b3: seq++ (wraps 63 -> 0), fifo_clk toggles, return to IDLE; fifo_write=0 next cycle.
//  - Latency: first fifo_write cycle starts 1 cycle (mono) or 2 cycles (stereo) after the tick cycle.
//  - Space is checked only at the tick; the pointers are not re-checked mid-message.
//  - direction or channels changing mid-message: the current message completes unchanged.
//  - SAMPLE_DIV >= 8 guarantees a tick never arrives outside IDLE.
//  - fifo_data holds its last byte while fifo_write=0.
// TESTING
//  1 mono, direction=1, slot_data=6'h15, FIFO empty -> bytes 80,15,15,80; fifo_write high 4 cycles;
//    fifo_clk 0->1.
//  2 stereo, seq=1, L=6'h0A then R=6'h31 on the next cycle -> bytes 81,0A,31,BA; writes start 2 cycles
//    after the tick.
//  3 fifo_addr_in=7FD, fifo_addr_out=000 (free=2) -> no fifo_write, overflow_count 0->1, seq unchanged;
//    the next tick with FIFO drained writes a message with the same seq.
//  4 direction=0 for 4 ticks -> fifo_write stays 0, overflow_count stays 0, fifo_clk stays constant.
//  5 64 consecutive mono messages -> b0 of the 65th message = 80; fifo_clk toggled 64 times;
//    overflow_count forced past 255 stays at 255.
//  6 reset asserted after the b1 write -> outputs go to reset values immediately; after release,
//    the first message is complete, with b0=80.

Source files
------------

// File: rtl/dummy_adc_if.sv
// FIFO-side bus of the dummy ADC: byte write port, message strobe and the FIFO pointers.
// The ADC side is the master; the FIFO owning the pointers is the slave.
interface dummy_adc_if #(
    parameter int ADDR_W = 11
);
    logic              fifo_clk;
    logic [7:0]        fifo_data;
    logic              fifo_write;
    logic [ADDR_W-1:0] fifo_addr_in;
    logic [ADDR_W-1:0] fifo_addr_out;

    modport master (
        output fifo_clk,
        output fifo_data,
        output fifo_write,
        input  fifo_addr_in,
        input  fifo_addr_out
    );

    modport slave (
        input  fifo_clk,
        input  fifo_data,
        input  fifo_write,
        output fifo_addr_in,
        output fifo_addr_out
    );
endinterface

// File: rtl/dummy_adc.sv
// Stand-in ADC: samples the 6-bit slot port once per tick and frames each sample
// into a 4-byte message {header, L, R, checksum} written into the slot FIFO.
module dummy_adc #(
    parameter int SAMPLE_DIV = 256,
    parameter int ADDR_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       slot_data,
    input  logic             direction,
    input  logic             channels,
    output logic [7:0]       overflow_count,
    dummy_adc_if.master      fifo
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAP_R,
        WRITE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [5:0]        seq, seq_n;
    logic [5:0]        samp_l, samp_l_n;
    logic [5:0]        samp_r, samp_r_n;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              fifo_clk_q, fifo_clk_n;
    logic [7:0]        fifo_data_q, fifo_data_n;
    logic              fifo_write_q, fifo_write_n;
    logic [7:0]        ovf_q, ovf_n;
    logic [ADDR_W-1:0] used;
    logic              no_room;
    logic [7:0]        b0, b1, b2, b3;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    // free = 2**ADDR_W - 1 - used, which in ADDR_W-bit arithmetic is simply ~used
    assign used    = fifo.fifo_addr_in - fifo.fifo_addr_out;
    assign no_room = (~used) < ADDR_W'(4);

    assign b0 = {2'b10, seq};
    assign b1 = {2'b00, samp_l};
    assign b2 = {2'b00, samp_r};
    assign b3 = b0 ^ b1 ^ b2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Outputs are computed one cycle ahead so each byte appears registered on the write cycle
    always_comb begin
        state_n      = state;
        byte_idx_n   = byte_idx;
        seq_n        = seq;
        samp_l_n     = samp_l;
        samp_r_n     = samp_r;
        fifo_clk_n   = fifo_clk_q;
        fifo_data_n  = fifo_data_q;
        fifo_write_n = 1'b0;
        ovf_n        = ovf_q;

        case (state)
            IDLE: begin
                if (tick && direction) begin
                    if (no_room) begin
                        if (ovf_q != 8'hFF) begin
                            ovf_n = ovf_q + 8'd1;
                        end
                    end else begin
                        samp_l_n = slot_data;
                        if (!channels) begin
                            samp_r_n     = slot_data;
                            fifo_write_n = 1'b1;
                            fifo_data_n  = b0;
                            byte_idx_n   = 2'd1;
                            state_n      = WRITE;
                        end else begin
                            state_n = CAP_R;
                        end
                    end
                end
            end
            CAP_R: begin
                samp_r_n     = slot_data;
                fifo_write_n = 1'b1;
                fifo_data_n  = b0;
                byte_idx_n   = 2'd1;
                state_n      = WRITE;
            end
            WRITE: begin
                fifo_write_n = 1'b1;
                case (byte_idx)
                    2'd0:    fifo_data_n = b0;
                    2'd1:    fifo_data_n = b1;
                    2'd2:    fifo_data_n = b2;
                    default: fifo_data_n = b3;
                endcase
                byte_idx_n = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    seq_n      = seq + 6'd1;
                    fifo_clk_n = ~fifo_clk_q;
                    byte_idx_n = 2'd0;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            seq          <= 6'd0;
            samp_l       <= 6'd0;
            samp_r       <= 6'd0;
            fifo_clk_q   <= 1'b0;
            fifo_data_q  <= 8'd0;
            fifo_write_q <= 1'b0;
            ovf_q        <= 8'd0;
        end else begin
            state        <= state_n;
            byte_idx     <= byte_idx_n;
            seq          <= seq_n;
            samp_l       <= samp_l_n;
            samp_r       <= samp_r_n;
            fifo_clk_q   <= fifo_clk_n;
            fifo_data_q  <= fifo_data_n;
            fifo_write_q <= fifo_write_n;
            ovf_q        <= ovf_n;
        end
    end

    assign fifo.fifo_clk   = fifo_clk_q;
    assign fifo.fifo_data  = fifo_data_q;
    assign fifo.fifo_write = fifo_write_q;
    assign overflow_count  = ovf_q;

endmodule

// File: tb/tb_dummy_adc.sv
// Directed bench for dummy_adc: a vector table of single-tick messages plus
// hand sequences for mid-message reset, sequence wrap and overflow saturation.
module tb_dummy_adc;

    localparam int SAMPLE_DIV = 8;
    localparam int ADDR_W     = 11;

    typedef struct {
        logic              dir;
        logic              ch;
        logic              flip;
        logic [5:0]        l;
        logic [5:0]        r;
        logic [ADDR_W-1:0] a_in;
        logic [ADDR_W-1:0] a_out;
        int                exp_nwr;
        int                exp_first;
        logic [31:0]       exp_msg;
        int                exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] slot_data;
    logic       direction;
    logic       channels;
    logic [7:0] overflow_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] last_byte;

    dummy_adc_if #(.ADDR_W(ADDR_W)) fifo_bus ();

    dummy_adc #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .slot_data      (slot_data),
        .direction      (direction),
        .channels       (channels),
        .overflow_count (overflow_count),
        .fifo           (fifo_bus)
    );

    always #5 clk = ~clk;

    // Reference framing: header, left, right, xor checksum, first byte in the top bits
    function automatic logic [31:0] make_msg(input logic [5:0] seq, input logic [5:0] l,
                                             input logic [5:0] r);
        logic [7:0] b0, b1, b2;
        b0 = {2'b10, seq};
        b1 = {2'b00, l};
        b2 = {2'b00, r};
        return {b0, b1, b2, b0 ^ b1 ^ b2};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Entered at the falling edge just before a tick edge; leaves at the same phase one period later
    task automatic applyStimulus(input vec_t v, output logic [31:0] msg, output int n_wr,
                                 output int first_off, output int toggles);
        logic prev_clk;
        direction              = v.dir;
        channels               = v.ch;
        slot_data              = v.l;
        fifo_bus.fifo_addr_in  = v.a_in;
        fifo_bus.fifo_addr_out = v.a_out;
        msg       = 32'd0;
        n_wr      = 0;
        first_off = -1;
        toggles   = 0;
        prev_clk  = fifo_bus.fifo_clk;
        for (int k = 0; k < SAMPLE_DIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                slot_data = v.r;
                if (v.flip) begin
                    direction = 1'b0;
                    channels  = ~channels;
                end
            end
            if (fifo_bus.fifo_write) begin
                if (first_off < 0) first_off = k;
                if (n_wr < 4) msg = {msg[23:0], fifo_bus.fifo_data};
                n_wr++;
            end
            if (fifo_bus.fifo_clk != prev_clk) toggles++;
            prev_clk = fifo_bus.fifo_clk;
        end
    endtask

    task automatic runVec(input string tag, input vec_t v, output int toggles);
        logic [31:0] msg;
        int          n_wr;
        int          first_off;
        applyStimulus(v, msg, n_wr, first_off, toggles);
        checkOutput({tag, " writes"}, n_wr, v.exp_nwr);
        checkOutput({tag, " latency"}, first_off, v.exp_first);
        checkOutput({tag, " bytes"}, int'(msg), int'(v.exp_msg));
        checkOutput({tag, " overflow"}, int'(overflow_count), v.exp_ovf);
        checkOutput({tag, " strobe"}, toggles, (v.exp_nwr == 4) ? 1 : 0);
        if (v.exp_nwr == 4) last_byte = v.exp_msg[7:0];
        checkOutput({tag, " hold"}, int'(fifo_bus.fifo_data), int'(last_byte));
    endtask

    task automatic realign();
        repeat (SAMPLE_DIV - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    vec_t vecs[13];

    initial begin
        vec_t v;
        int   tog;
        int   tog_sum;
        int   ovf_exp;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'h15, 6'h2E, 11'h000, 11'h000, 4,  0, 32'h80151580, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'h0A, 6'h31, 11'h000, 11'h000, 4,  1, 32'h810A31BA, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'h2C, 6'h2C, 11'h7FD, 11'h000, 0, -1, 32'h00000000, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, 11'h000, 11'h000, 4,  0, 32'h823F3F82, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'h12, 6'h12, 11'h000, 11'h000, 0, -1, 32'h00000000, 1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'h12, 6'h12, 11'h000, 11'h000, 0, -1, 32'h00000000, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'h12, 6'h12, 11'h7FF, 11'h000, 0, -1, 32'h00000000, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'h12, 6'h12, 11'h000, 11'h000, 0, -1, 32'h00000000, 1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 6'h00, 6'h3F, 11'h7FB, 11'h000, 4,  1, 32'h83003FBC, 1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 6'h01, 6'h01, 11'h002, 11'h005, 0, -1, 32'h00000000, 2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 6'h2A, 6'h01, 11'h003, 11'h7FF, 4,  0, 32'h842A2A84, 2};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 6'h11, 6'h22, 11'h000, 11'h000, 4,  1, 32'h851122B6, 2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 6'h3E, 6'h05, 11'h000, 11'h000, 4,  1, 32'h863E05BD, 2};

        reset                  = 1'b0;
        direction              = 1'b0;
        channels               = 1'b0;
        slot_data              = 6'h00;
        fifo_bus.fifo_addr_in  = '0;
        fifo_bus.fifo_addr_out = '0;
        last_byte              = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset fifo_write", int'(fifo_bus.fifo_write), 0);
        checkOutput("reset fifo_data", int'(fifo_bus.fifo_data), 0);
        checkOutput("reset fifo_clk", int'(fifo_bus.fifo_clk), 0);
        checkOutput("reset overflow", int'(overflow_count), 0);
        reset = 1'b1;
        realign();

        for (int i = 0; i < 13; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i], tog);
        end

        // Reset in the middle of a message, right after the second byte is on the bus
        direction              = 1'b1;
        channels               = 1'b0;
        slot_data              = 6'h07;
        fifo_bus.fifo_addr_in  = '0;
        fifo_bus.fifo_addr_out = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst b0", int'(fifo_bus.fifo_data), 8'h87);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst b1", int'(fifo_bus.fifo_data), 8'h07);
        reset = 1'b0;
        #1;
        checkOutput("midrst fifo_write", int'(fifo_bus.fifo_write), 0);
        checkOutput("midrst fifo_data", int'(fifo_bus.fifo_data), 0);
        checkOutput("midrst fifo_clk", int'(fifo_bus.fifo_clk), 0);
        checkOutput("midrst overflow", int'(overflow_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        last_byte = 8'h00;
        realign();

        // 64 mono messages from a fresh sequence, then the 65th must wrap back to header 80
        tog_sum = 0;
        for (int i = 0; i < 64; i++) begin
            v = '{1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 11'h000, 11'h000, 4, 0, 32'h0, 0};
            v.l       = i[5:0] ^ 6'h15;
            v.r       = ~v.l;
            v.exp_msg = make_msg(i[5:0], v.l, v.l);
            runVec($sformatf("seq%0d", i), v, tog);
            tog_sum += tog;
        end
        checkOutput("strobe total", tog_sum, 64);
        checkOutput("strobe level64", int'(fifo_bus.fifo_clk), 0);
        v = '{1'b1, 1'b0, 1'b0, 6'h1B, 6'h1B, 11'h000, 11'h000, 4, 0, 32'h801B1B80, 0};
        runVec("seq65", v, tog);
        checkOutput("strobe level65", int'(fifo_bus.fifo_clk), 1);

        // Full FIFO: every tick drops a message until the counter pins at 255
        for (int i = 0; i < 260; i++) begin
            ovf_exp = (i + 1 > 255) ? 255 : i + 1;
            v = '{1'b1, 1'b0, 1'b0, 6'h33, 6'h33, 11'h7FF, 11'h000, 0, -1, 32'h0, 0};
            v.exp_ovf = ovf_exp;
            runVec($sformatf("drop%0d", i), v, tog);
        end

        v = '{1'b1, 1'b0, 1'b0, 6'h09, 6'h09, 11'h000, 11'h000, 4, 0, 32'h0, 255};
        v.exp_msg = make_msg(6'd1, 6'h09, 6'h09);
        runVec("after drops", v, tog);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
